// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the 16-bit RISC control path (package risc_pkg):
// state encoding, opcode map, ALUOp and pc_src codes.
package risc_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } ctrl_state_t;

    localparam logic [3:0] OP_LD       = 4'b0000;
    localparam logic [3:0] OP_ST       = 4'b0001;
    localparam logic [3:0] OP_RT_FIRST = 4'b0010;
    localparam logic [3:0] OP_RT_LAST  = 4'b1001;
    localparam logic [3:0] OP_BEQ      = 4'b1011;
    localparam logic [3:0] OP_BNE      = 4'b1100;
    localparam logic [3:0] OP_JMP      = 4'b1101;

    localparam logic [1:0] ALUOP_ADDR  = 2'b10;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b00;

    localparam logic [1:0] PCSRC_INC   = 2'b00;
    localparam logic [1:0] PCSRC_BR    = 2'b01;
    localparam logic [1:0] PCSRC_JMP   = 2'b10;

    function automatic logic is_rtype(input logic [3:0] op);
        return (op >= OP_RT_FIRST) && (op <= OP_RT_LAST);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    // 1010, 1110 and 1111 have no instruction assigned.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'b1010) || (op == 4'b1110) || (op == 4'b1111);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Instruction/data memory handshake bundle between the sequencer (master)
// and the memory side (slave).
interface multicycle_ctrl_fsm_if;

    logic imem_req;
    logic imem_ready;
    logic ir_load;
    logic dmem_ready;
    logic mem_read;
    logic mem_write;

    modport master (
        output imem_req, ir_load, mem_read, mem_write,
        input  imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, ir_load, mem_read, mem_write,
        output imem_ready, dmem_ready
    );

endinterface

// File: rtl/multicycle_ctrl_fsm_wait_timer.sv
// ctrl_wait_timer: counts consecutive not-ready cycles of a memory handshake
// and flags a timeout when the count reaches TIMEOUT with ready still low.
module ctrl_wait_timer #(
    parameter int unsigned WAIT_W  = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic ready_i,
    output logic expired_o
);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    // Any cycle outside a waiting state, or any ready, returns the count to 0,
    // so every entry into FETCH/MEM starts from zero.
    always_comb begin
        cnt_d = '0;
        if (active_i && !ready_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = active_i && !ready_i && (cnt_q == WAIT_W'(TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit RISC core.
// Define ILLEGAL_TRAP_EN to halt with bus_error on illegal opcodes instead of retiring them as NOPs.
module multicycle_ctrl_fsm
    import risc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned WAIT_W  = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_ctrl_fsm_if.master    mem_bus,
    input  logic [3:0]               opcode,
    input  logic                     zero_flag,
    output logic                     pc_write,
    output logic [1:0]               pc_src,
    output logic [1:0]               alu_op,
    output logic                     alu_src,
    output logic                     reg_dst,
    output logic                     reg_write,
    output logic                     mem_to_reg,
    output logic                     instr_done,
    output logic [CNT_W-1:0]         instr_count,
    output logic                     bus_error,
    output logic [2:0]               state_o
);

    ctrl_state_t      state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             berr_q, berr_d;
    logic [CNT_W-1:0] count_q;
    logic             wait_active, wait_ready, wait_expired;

    assign wait_active = (state_q == FETCH) || (state_q == MEM);
    assign wait_ready  = (state_q == FETCH) ? mem_bus.imem_ready : mem_bus.dmem_ready;

    ctrl_wait_timer #(
        .WAIT_W  (WAIT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .active_i  (wait_active),
        .ready_i   (wait_ready),
        .expired_o (wait_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            op_q    <= '0;
            berr_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            berr_q  <= berr_d;
            if (instr_done) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        berr_d  = berr_q;
        case (state_q)
            FETCH: begin
                if (mem_bus.imem_ready) begin
                    state_d = DECODE;
                end else if (wait_expired) begin
                    state_d = HALT;
                    berr_d  = 1'b1;
                end
            end
            DECODE: begin
                op_d = opcode;
                if (opcode == OP_JMP) begin
                    state_d = FETCH;
                end else if (is_illegal(opcode)) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = HALT;
                    berr_d  = 1'b1;
`else
                    state_d = FETCH;
`endif
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_mem_op(op_q)) begin
                    state_d = MEM;
                end else if (is_rtype(op_q)) begin
                    state_d = WB;
                end else begin
                    state_d = FETCH;
                end
            end
            MEM: begin
                if (mem_bus.dmem_ready) begin
                    state_d = (op_q == OP_LD) ? WB : FETCH;
                end else if (wait_expired) begin
                    state_d = HALT;
                    berr_d  = 1'b1;
                end
            end
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // DECODE decides from the live opcode; later states use the latched copy.
    always_comb begin
        mem_bus.imem_req  = 1'b0;
        mem_bus.ir_load   = 1'b0;
        mem_bus.mem_read  = 1'b0;
        mem_bus.mem_write = 1'b0;
        pc_write          = 1'b0;
        pc_src            = PCSRC_INC;
        alu_op            = ALUOP_RTYPE;
        alu_src           = 1'b0;
        reg_dst           = 1'b0;
        reg_write         = 1'b0;
        mem_to_reg        = 1'b0;
        instr_done        = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_bus.imem_req = 1'b1;
                    if (mem_bus.imem_ready) begin
                        mem_bus.ir_load = 1'b1;
                        pc_write        = 1'b1;
                        pc_src          = PCSRC_INC;
                    end
                end
                DECODE: begin
                    if (opcode == OP_JMP) begin
                        pc_write   = 1'b1;
                        pc_src     = PCSRC_JMP;
                        instr_done = 1'b1;
                    end else if (is_illegal(opcode)) begin
`ifndef ILLEGAL_TRAP_EN
                        instr_done = 1'b1;
`endif
                    end
                end
                EXEC: begin
                    if (is_mem_op(op_q)) begin
                        alu_op  = ALUOP_ADDR;
                        alu_src = 1'b1;
                    end else if ((op_q == OP_BEQ) || (op_q == OP_BNE)) begin
                        alu_op     = ALUOP_BR;
                        pc_src     = PCSRC_BR;
                        pc_write   = (op_q == OP_BEQ) ? zero_flag : !zero_flag;
                        instr_done = 1'b1;
                    end
                end
                MEM: begin
                    mem_bus.mem_read  = (op_q == OP_LD);
                    mem_bus.mem_write = (op_q == OP_ST);
                    instr_done        = (op_q == OP_ST) && mem_bus.dmem_ready;
                end
                WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    mem_to_reg = (op_q == OP_LD);
                    reg_dst    = (op_q != OP_LD);
                end
                default: ;
            endcase
        end
    end

    assign instr_count = count_q;
    assign bus_error   = berr_q;
    assign state_o     = state_q;

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Multi-cycle sequencer for the 16-bit RISC core. Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes. Produces the 2-bit ALUOp consumed by alu_control: 10 = address add, 01 = branch compare, 00 = opcode-decoded. Handshakes with the instruction and data memories and retires one instruction per pass.

Parameters:
TIMEOUT, 15, max cycles to wait for imem_ready/dmem_ready before bus error (1..2^WAIT_W-1)
WAIT_W, 4, width of the wait counter
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
opcode  in  4  instruction[15:12] from IR; valid from DECODE onward
zero_flag  in  1  ALU zero result
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
ir_load  out  1  load IR
pc_write  out  1  PC update enable
pc_src  out  2  00 PC+2, 01 branch target, 10 jump target
alu_op  out  2  to alu_control ALUOp
alu_src  out  1  1 = immediate operand
reg_dst  out  1  1 = rd field (R-type), 0 = rt
reg_write  out  1  register file write
mem_to_reg  out  1  writeback from memory
mem_read  out  1  data memory read request
mem_write  out  1  data memory write request
instr_done  out  1  one-cycle retire pulse
instr_count  out  CNT_W  retired instructions, wraps
bus_error  out  1  sticky memory timeout flag
state_o  out  3  current state encoding, for debug

Behaviour:
- Opcode classes: 0000 LD, 0001 ST, 0010-1001 R-type, 1011 BEQ, 1100 BNE, 1101 JMP. 1010, 1110 and 1111 are illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset: state=FETCH, wait counter, instr_count, latched opcode and bus_error all 0.
  - While rst=1, every output strobe is 0.
  - First FETCH cycle is the cycle after rst falls.
- Outputs are combinational from state and the latched opcode. pc_write in EXEC also depends on zero_flag.
- FETCH: imem_req=1.
  - On imem_ready: ir_load=1, pc_write=1, pc_src=00, go to DECODE.
- DECODE: latch opcode.
  - JMP: pc_write=1, pc_src=10, instr_done=1, go to FETCH.
  - Otherwise go to EXEC.
- EXEC: alu_op is 10 for LD/ST, 01 for BEQ/BNE, 00 for R-type. alu_src=1 for LD/ST only.
  - LD/ST: go to MEM.
  - R-type: go to WB.
  - BEQ: pc_write=zero_flag, pc_src=01, instr_done=1, go to FETCH.
  - BNE: pc_write=!zero_flag, pc_src=01, instr_done=1, go to FETCH.
- MEM: mem_read (LD) or mem_write (ST) held high until dmem_ready.
  - LD on dmem_ready: go to WB.
  - ST on dmem_ready: instr_done=1, go to FETCH.
- WB: reg_write=1, instr_done=1, go to FETCH.
  - LD: mem_to_reg=1, reg_dst=0.
  - R-type: mem_to_reg=0, reg_dst=1.
- Path latencies with zero-wait memory:
  - JMP: 2 cycles.
  - Branch: 3 cycles.
  - R-type: 4 cycles.
  - ST: 4 cycles.
  - LD: 5 cycles.
- Wait counter:
  - Cleared on entry to FETCH and MEM, and on each ready.
  - Increments each cycle in FETCH/MEM while ready=0.
  - If ready is still 0 when the counter equals TIMEOUT: bus_error=1 (sticky), go to HALT.
  - Ready arriving in the same cycle as the counter reaching TIMEOUT counts as success.
- HALT: all strobes 0; leave only via rst.
- instr_count increments on every instr_done and wraps from 2^CNT_W-1 to 0.
- Illegal opcode, feature off: DECODE treats it as a NOP, pulses instr_done, returns to FETCH.
- Reset in any state, mid-handshake included: next state FETCH; no strobe is asserted in the reset cycle.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE sets bus_error=1 and goes to HALT. No instr_done pulse; instr_count unchanged.
- Undefined: the illegal opcode is retired as a NOP, as described in Behaviour.

Decomposition:
- Shared package risc_pkg holds:
  - state enum typedef ctrl_state_t.
  - Opcode constants OP_LD through OP_JMP.
  - ALUOp constants ALUOP_ADDR=2'b10, ALUOP_BR=2'b01, ALUOP_RTYPE=2'b00.
  - pc_src constants.
- One sub-module, ctrl_wait_timer: wait counter plus timeout compare, parameterised by WAIT_W and TIMEOUT.

Test Plan:
- R-type ADD (0010), zero-wait memory -> states 0,1,2,4,0; alu_op=00 in EXEC; reg_write=1 and reg_dst=1 in WB; instr_count goes 0 to 1.
- LD (0000) with dmem_ready delayed 3 cycles -> mem_read high for 4 cycles; alu_op=10, alu_src=1 in EXEC; WB has mem_to_reg=1; total 8 cycles.
- BEQ (1011) run twice, zero_flag=1 then zero_flag=0 -> pc_write=1, pc_src=01 on the first; pc_write=0 on the second; alu_op=01 and instr_done=1 both times.
- imem_ready held low -> bus_error=1 and state_o=5 after TIMEOUT+1 FETCH cycles; stays there until rst, then FETCH resumes with bus_error=0.
- rst pulsed during MEM of a ST -> mem_write=0 in the reset cycle; next cycle state FETCH, instr_count=0.
- Opcode 1111 -> feature off: NOP retire, instr_count+1. ILLEGAL_TRAP_EN defined: HALT, bus_error=1, no count increment.
